qspi_read_sched: RTL and testbench

//   Two-port read scheduler for the external QSPI boot flash (qspi_cs/qspi_sck/qspi_dq[3:0]).

---
 rtl/qspi_sched_pkg.sv | 25 ++
 rtl/qspi_sck_gen.sv | 40 ++++
 rtl/qspi_read_sched.sv | 171 +++++++++++++++++
 tb/tb_qspi_read_sched.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qspi_sched_pkg.sv
// Shared types and constants for the QSPI read scheduler.
package qspi_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_RESP
  } state_t;

  localparam logic [7:0] CMD_READ = 8'h03;

  localparam int CMD_BITS   = 8;
  localparam int ADDR_BITS  = 24;
  localparam int DATA_BITS  = 32;
  localparam int TOTAL_BITS = CMD_BITS + ADDR_BITS + DATA_BITS;

  // The flash returns bytes in address order, MSB first per byte; the first
  // byte received belongs in the least significant lane of the result.
  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/qspi_sck_gen.sv
// SPI mode-0 serial clock generator: DIV cycles per half period, with strobes
// that are high in the cycle whose closing clock edge flips sck.
module qspi_sck_gen
  import qspi_sched_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  output logic sck,
  output logic rise,
  output logic fall
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_reg;
  logic          sck_reg;
  logic          half_done;

  assign half_done = (cnt_reg == CW'(DIV - 1));
  assign rise      = en & half_done & ~sck_reg;
  assign fall      = en & half_done & sck_reg;
  assign sck       = sck_reg;

  // Half-period counter; disabling parks sck low with a fresh count.
  always_ff @(posedge clock) begin
    if (reset || !en) begin
      cnt_reg <= '0;
      sck_reg <= 1'b0;
    end else if (half_done) begin
      cnt_reg <= '0;
      sck_reg <= ~sck_reg;
    end else begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

endmodule

// File: rtl/qspi_read_sched.sv
// Two-port round-robin scheduler turning word reads into single-line
// READ (0x03) transactions on the QSPI boot flash.
module qspi_read_sched
  import qspi_sched_pkg::*;
#(
  parameter int DIV     = 2,
  parameter int CS_IDLE = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [23:0] req_addr0,
  input  logic [23:0] req_addr1,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [31:0] rsp_data,
  output logic        qspi_cs_n,
  output logic        qspi_sck,
  output logic [3:0]  qspi_dq_o,
  output logic [3:0]  qspi_dq_oe,
  input  logic [3:0]  qspi_dq_i
);

  state_t                  state_reg, state_next;
  logic [15:0]             cnt_reg, cnt_next;
  logic [TOTAL_BITS-1:0]   shift_reg;
  logic [6:0]              bit_cnt_reg;
  logic [DATA_BITS-1:0]    data_reg;
  logic                    port_reg;
  logic                    last_grant_reg;
  logic                    rsp_valid_reg;
  logic [31:0]             rsp_data_reg;

  logic [1:0]  grant;
  logic        cs_active;
  logic        sck_en;
  logic        sck_rise;
  logic        sck_fall;
  logic [23:0] sel_addr;
  logic        unused_bits;

  // Only MISO and the word-aligned address bits carry information.
  assign unused_bits = ^{qspi_dq_i[3:2], qspi_dq_i[0], req_addr0[1:0], req_addr1[1:0]};

  assign sel_addr = req_ready[1] ? req_addr1 : req_addr0;

  qspi_sck_gen #(.DIV(DIV)) u_sck_gen (
    .clock (clock),
    .reset (reset),
    .en    (sck_en),
    .sck   (qspi_sck),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic, arbitration and pad-facing outputs.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    grant      = 2'b00;
    req_ready  = 2'b00;
    cs_active  = 1'b0;
    sck_en     = 1'b0;

    // On a tie the port that did not win last time gets the grant.
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant_reg ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase

    case (state_reg)
      ST_IDLE: begin
        // Gating with reset keeps a fire from being reported while the
        // request would be discarded anyway.
        req_ready = reset ? 2'b00 : grant;
        if (|req_ready) begin
          state_next = ST_SETUP;
          cnt_next   = '0;
        end
      end
      ST_SETUP: begin
        cs_active = 1'b1;
        if (cnt_reg == 16'(DIV - 1)) begin
          state_next = ST_SHIFT;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      ST_SHIFT: begin
        cs_active = 1'b1;
        sck_en    = 1'b1;
        if (sck_fall && bit_cnt_reg == 7'(TOTAL_BITS)) begin
          state_next = ST_HOLD;
          cnt_next   = '0;
        end
      end
      ST_HOLD: begin
        if (cnt_reg == 16'(CS_IDLE - 1)) begin
          state_next = ST_RESP;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      ST_RESP: begin
        if (rsp_valid_reg && rsp_ready[port_reg]) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign qspi_cs_n  = ~cs_active;
  assign qspi_dq_o  = {3'b000, cs_active & shift_reg[TOTAL_BITS-1]};
  assign qspi_dq_oe = cs_active ? 4'b0001 : 4'b0000;
  assign rsp_valid  = rsp_valid_reg ? (port_reg ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_data   = rsp_data_reg;

  // Datapath: request capture, serial shifting, response register.
  always_ff @(posedge clock) begin
    if (reset) begin
      shift_reg      <= '0;
      bit_cnt_reg    <= '0;
      data_reg       <= '0;
      port_reg       <= 1'b0;
      last_grant_reg <= 1'b1;
      rsp_valid_reg  <= 1'b0;
      rsp_data_reg   <= '0;
    end else begin
      if (state_reg == ST_IDLE && |req_ready) begin
        port_reg       <= req_ready[1];
        last_grant_reg <= req_ready[1];
        shift_reg      <= {CMD_READ, sel_addr[23:2], 2'b00, {DATA_BITS{1'b0}}};
        bit_cnt_reg    <= '0;
      end
      if (state_reg == ST_SHIFT) begin
        if (sck_rise) begin
          bit_cnt_reg <= bit_cnt_reg + 7'd1;
          if (bit_cnt_reg >= 7'(CMD_BITS + ADDR_BITS)) begin
            data_reg <= {data_reg[DATA_BITS-2:0], qspi_dq_i[1]};
          end
        end
        if (sck_fall) begin
          shift_reg <= {shift_reg[TOTAL_BITS-2:0], 1'b0};
        end
      end
      if (state_reg == ST_HOLD) begin
        rsp_data_reg <= byte_swap(data_reg);
      end
      // Valid rises one cycle into RESP and falls on the handshake edge.
      rsp_valid_reg <= (state_reg == ST_RESP) && !(rsp_valid_reg && rsp_ready[port_reg]);
    end
  end

endmodule

// File: tb/tb_qspi_read_sched.sv
// Scoreboard bench for qspi_read_sched with a byte-array flash model.
module tb_qspi_read_sched;

  localparam int DIV     = 2;
  localparam int CS_IDLE = 4;
  localparam int LAT     = DIV + 128 * DIV + CS_IDLE + 1;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [23:0] req_addr0 = '0;
  logic [23:0] req_addr1 = '0;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready = 2'b00;
  logic [31:0] rsp_data;
  logic        qspi_cs_n;
  logic        qspi_sck;
  logic [3:0]  qspi_dq_o;
  logic [3:0]  qspi_dq_oe;
  logic [3:0]  qspi_dq_i = 4'b0000;

  qspi_read_sched #(.DIV(DIV), .CS_IDLE(CS_IDLE)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .qspi_cs_n(qspi_cs_n), .qspi_sck(qspi_sck),
    .qspi_dq_o(qspi_dq_o), .qspi_dq_oe(qspi_dq_oe), .qspi_dq_i(qspi_dq_i)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- flash contents ----------------
  logic [7:0] mem [logic [23:0]];

  function automatic logic [7:0] mem_rd(input logic [23:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ {a[12:8], a[23:21]} ^ 8'hA5;
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct {
    logic        port;
    logic [31:0] data;
    int          fire_cyc;
  } exp_t;

  exp_t        sb[$];
  logic [23:0] fq[$];      // addresses the flash should see on MOSI
  int          glog[$];    // grant order
  logic [23:0] cq0[$], cq1[$];
  logic [1:0]  fired_last = 2'b00;
  logic        last_model = 1'b1;
  int          cyc = 0;
  logic        hold_off = 1'b0;
  logic [31:0] last_rsp_data = '0;
  int          last_rsp_port = -1;

  // Fire observer: checks arbitration and records the expected response.
  always @(posedge clock) begin
    logic [1:0]  fire;
    logic        p;
    logic [23:0] aa;
    exp_t        e;
    cyc = cyc + 1;
    if (reset) begin
      last_model = 1'b1;
      sb.delete();
      fq.delete();
      fired_last = 2'b00;
    end else begin
      fire = req_valid & req_ready;
      fired_last = fire;
      if (fire != 2'b00) begin
        chk("one_grant", 64'($countones(fire)), 64'd1);
        p = fire[1];
        if (req_valid == 2'b11) chk("rr_grant", 64'(p), 64'(!last_model));
        else chk("sole_grant", 64'(p), 64'(req_valid[1]));
        last_model = p;
        glog.push_back(int'(p));
        aa = p ? req_addr1 : req_addr0;
        aa[1:0] = 2'b00;
        e.port = p;
        e.data = {mem_rd(aa + 24'd3), mem_rd(aa + 24'd2), mem_rd(aa + 24'd1), mem_rd(aa)};
        e.fire_cyc = cyc;
        sb.push_back(e);
        fq.push_back(aa);
        $display("issue port=%0d addr=%06h exp=%08h cyc=%0d", p, aa, e.data, cyc);
      end
    end
  end

  // Request driver: keeps each port's valid up while it has queued reads.
  always @(posedge clock) begin
    #1;
    if (reset) begin
      req_valid = 2'b00;
    end else begin
      if (fired_last[0]) req_valid[0] = 1'b0;
      if (fired_last[1]) req_valid[1] = 1'b0;
      if (!req_valid[0] && cq0.size() != 0) begin
        req_addr0 = cq0.pop_front();
        req_valid[0] = 1'b1;
      end
      if (!req_valid[1] && cq1.size() != 0) begin
        req_addr1 = cq1.pop_front();
        req_valid[1] = 1'b1;
      end
    end
  end

  // Response-ready driver.
  always @(posedge clock) begin
    #1;
    rsp_ready = hold_off ? 2'b00 : 2'($urandom_range(0, 3));
  end

  // ---------------- flash model ----------------
  logic        prev_sck = 1'b0;
  logic        prev_cs  = 1'b1;
  int          fl_n = 0;
  logic [31:0] fl_cap = '0;

  always @(qspi_sck or qspi_cs_n) begin
    int k;
    logic [7:0] b;
    if (!qspi_cs_n && prev_cs) begin
      fl_n = 0;
      fl_cap = '0;
    end
    if (qspi_cs_n) fl_n = 0;
    if (!qspi_cs_n && qspi_sck && !prev_sck) begin
      if (fl_n < 32) fl_cap = {fl_cap[30:0], qspi_dq_o[0]};
      fl_n = fl_n + 1;
      if (fl_n == 32) begin
        chk("mosi_cmd", 64'(fl_cap[31:24]), 64'h03);
        if (fq.size() != 0) chk("mosi_addr", 64'(fl_cap[23:0]), 64'(fq.pop_front()));
        else chk("mosi_unexpected", 64'd1, 64'd0);
      end
    end
    if (!qspi_cs_n && !qspi_sck && prev_sck && fl_n >= 32 && fl_n < 64) begin
      k = fl_n - 32;
      b = mem_rd(fl_cap[23:0] + 24'(k / 8));
      qspi_dq_i[1] = b[7 - (k % 8)];
    end
    prev_sck = qspi_sck;
    prev_cs  = qspi_cs_n;
  end

  // ---------------- monitor ----------------
  logic [1:0]  prev_rv = 2'b00;
  logic [31:0] held = '0;
  int          hi_run = 0;
  logic        seen_low = 1'b0;

  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      prev_rv  = 2'b00;
      hi_run   = 0;
      seen_low = 1'b0;
    end else begin
      chk("dq_oe", 64'(qspi_dq_oe), qspi_cs_n ? 64'h0 : 64'h1);
      if (qspi_cs_n) begin
        hi_run++;
      end else begin
        if (seen_low && hi_run > 0) chk("cs_gap_ok", 64'(hi_run >= CS_IDLE), 64'd1);
        hi_run = 0;
        seen_low = 1'b1;
      end
      if (rsp_valid == 2'b11) chk("rsp_onehot", 64'(rsp_valid), 64'h1);
      for (int p = 0; p < 2; p++) begin
        if (rsp_valid[p]) begin
          if (!prev_rv[p]) begin
            if (sb.size() == 0) begin
              chk("rsp_unexpected", 64'd1, 64'd0);
            end else begin
              e = sb[0];
              chk("rsp_port", 64'(p), 64'(e.port));
              chk("rsp_data", 64'(rsp_data), 64'(e.data));
              chk("rsp_latency", 64'(cyc - e.fire_cyc), 64'(LAT));
              $display("resp port=%0d data=%08h exp=%08h lat=%0d", p, rsp_data, e.data, cyc - e.fire_cyc);
            end
            held = rsp_data;
          end else begin
            chk("rsp_held", 64'(rsp_data), 64'(held));
          end
          chk("resp_cs_n", 64'(qspi_cs_n), 64'd1);
          chk("resp_req_ready", 64'(req_ready), 64'd0);
          if (rsp_ready[p]) begin
            if (sb.size() != 0) void'(sb.pop_front());
            last_rsp_data = rsp_data;
            last_rsp_port = p;
          end
        end
      end
      prev_rv = rsp_valid;
    end
  end

  // ---------------- sequencing ----------------
  task automatic wait_idle(input string name);
    int n = 0;
    while (n < 6000 && !(cq0.size() == 0 && cq1.size() == 0 && req_valid == 2'b00 &&
                         sb.size() == 0 && rsp_valid == 2'b00)) begin
      @(negedge clock);
      n++;
    end
    if (n >= 6000) chk({name, "_timeout"}, 64'd1, 64'd0);
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1 reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  initial begin
    int n;
    logic [23:0] ra;
    repeat (4) @(posedge clock);
    #1 reset = 1'b0;

    // Reset state
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    chk("rst_cs_n", 64'(qspi_cs_n), 64'd1);
    chk("rst_sck", 64'(qspi_sck), 64'd0);
    chk("rst_dq_o", 64'(qspi_dq_o), 64'd0);
    chk("rst_dq_oe", 64'(qspi_dq_oe), 64'd0);

    // 1: single read
    mem[24'h000100] = 8'hEF; mem[24'h000101] = 8'hBE;
    mem[24'h000102] = 8'hAD; mem[24'h000103] = 8'hDE;
    cq0.push_back(24'h000100);
    wait_idle("t1");
    chk("t1_data", 64'(last_rsp_data), 64'hDEADBEEF);

    // 2: unaligned address on port 1
    cq1.push_back(24'h000103);
    wait_idle("t2");
    chk("t2_port", 64'(last_rsp_port), 64'd1);
    chk("t2_data", 64'(last_rsp_data), 64'hDEADBEEF);

    // 3: tie after reset
    do_reset();
    glog.delete();
    for (int i = 0; i < 2; i++) begin
      cq0.push_back(24'($urandom));
      cq1.push_back(24'($urandom));
    end
    wait_idle("t3");
    chk("t3_grants", 64'(glog.size()), 64'd4);
    for (int i = 0; i < 4 && i < glog.size(); i++) chk("t3_grant_order", 64'(glog[i]), 64'(i % 2));

    // 4: backpressure
    hold_off = 1'b1;
    cq0.push_back(24'($urandom));
    n = 0;
    while (n < 2000 && rsp_valid[0] !== 1'b1) begin
      @(negedge clock);
      n++;
    end
    if (n >= 2000) chk("t4_timeout", 64'd1, 64'd0);
    repeat (20) @(posedge clock);
    #2 chk("t4_still_valid", 64'(rsp_valid), 64'h1);
    hold_off = 1'b0;
    wait_idle("t4");

    // 5: reset in the middle of the shift phase
    cq0.push_back(24'h000200);
    n = 0;
    while (n < 2000 && fl_n < 40) begin
      @(negedge clock);
      n++;
    end
    if (n >= 2000) chk("t5_timeout", 64'd1, 64'd0);
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1;
    chk("t5_cs_n", 64'(qspi_cs_n), 64'd1);
    chk("t5_sck", 64'(qspi_sck), 64'd0);
    chk("t5_rsp_valid", 64'(rsp_valid), 64'd0);
    reset = 1'b0;
    cq0.push_back(24'h000000);
    wait_idle("t5");
    chk("t5_data", 64'(last_rsp_data),
        64'({mem_rd(24'd3), mem_rd(24'd2), mem_rd(24'd1), mem_rd(24'd0)}));

    // 6: top of the address space
    mem[24'hFFFFFC] = 8'h11; mem[24'hFFFFFD] = 8'h22;
    mem[24'hFFFFFE] = 8'h33; mem[24'hFFFFFF] = 8'h44;
    cq1.push_back(24'hFFFFFC);
    wait_idle("t6");
    chk("t6_data", 64'(last_rsp_data), 64'h44332211);

    // Random traffic
    for (int i = 0; i < 12; i++) begin
      ra = 24'($urandom);
      case ($urandom_range(0, 2))
        0: cq0.push_back(ra);
        1: cq1.push_back(ra);
        default: begin
          cq0.push_back(ra);
          cq1.push_back(24'($urandom));
        end
      endcase
      repeat ($urandom_range(0, 300)) @(posedge clock);
    end
    wait_idle("rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
